dot_product_sequencer: RTL and testbench
========================================

# dot_product_sequencer

Control-side initiator for the 8×8-bit register file in the matrix multiplier datapath. Accepts a stream of eight products from the multiplier over a valid/ready handshake and writes them into the register file. It then runs a three-level pairwise adder-tree reduction through the register file's two read ports and the external combinational adder. The final dot-product sum is presented on a valid/ready result port.

## Interface
- WIDTH, 8, data width of products, sums and result
- ADDR_W, 3, register specifier width (8 registers); fixed, not for override
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- prod_valid  in  1  product beat valid
- prod_data  in  WIDTH  product from multiplier
- prod_ready  out  1  sequencer can accept a product this cycle
- sum_in  in  WIDTH  external adder output (term_1 + term_2 of register file)
- product_out  out  WIDTH  drives register file product_in
- reg_specifier_one  out  ADDR_W  write address / first read address
- reg_specifier_two  out  ADDR_W  second read address
- update_adder_regs  out  1  read strobe: register file loads term_1/term_2
- update_file_reg  out  1  write strobe: register file stores product_out at reg_specifier_one
- result_valid  out  1  result_data holds the finished sum
- result_data  out  WIDTH  dot-product sum
- result_ready  in  1  consumer accepts result
- busy  out  1  high in every state except LOAD

## Operation
- All outputs are registered. Reset value of every output is 0, except prod_ready, which is 1 in the first cycle after reset deasserts.
- States:
  - LOAD: prod_ready=1. Each accepted beat (prod_valid&prod_ready) writes register load_cnt. In the next cycle: update_file_reg=1, reg_specifier_one=load_cnt, product_out=prod_data. load_cnt increments. The 8th accept goes to DRAIN.
  - DRAIN: prod_ready=0. Issues the 8th write strobe, then goes to ADD_RD.
  - ADD_RD: update_adder_regs=1, reg_specifier_one=a, reg_specifier_two=b.
  - ADD_WAIT: strobes low. Captures sum_in into the sum register.
  - ADD_WR: update_file_reg=1, reg_specifier_one=a, product_out=captured sum. Then goes to the next pair (ADD_RD), or to DONE after the 7th add.
  - DONE: result_valid=1, result_data = sum captured in the last ADD_WAIT. On result_valid&result_ready, goes to LOAD; load_cnt and level are zeroed.
- Address generation: level L=0..2, stride s=1<<L, pair k=0..(4>>L)-1, a=k·2s, b=a+s.
  - Add order: (0,1),(2,3),(4,5),(6,7),(0,2),(4,6),(0,4).
- update_adder_regs and update_file_reg are never high in the same cycle, and each is a single-cycle pulse. This is required because the register file gives the read strobe priority.
- Arithmetic is done by the external adder, modulo 2^WIDTH. The sequencer never widens or saturates.
- Input handling:
  - prod_valid outside LOAD is ignored and prod_data is not sampled.
  - A new batch is not accepted until the result is consumed.
- Reset mid-operation (any state):
  - Next cycle: state LOAD, counters 0, strobes low, result_valid low; any pending result is discarded.
  - Register file contents are not cleared; the next batch overwrites all 8 registers.
- Reset wins over a simultaneous prod or result handshake.

## Timing
- The 8th product is accepted at cycle c. The 8th write strobe is at c+1 (DRAIN).
- Add i (0..6) occupies ADD_RD c+2+3i, ADD_WAIT c+3+3i, ADD_WR c+4+3i.
- result_valid rises at c+23 and holds with stable result_data until the handshake.
- prod_ready rises the cycle after the result handshake.
- Throughput: one product per cycle in LOAD; gaps in prod_valid stall the load without penalty.
- The register file must present term_1/term_2 such that sum_in is valid within the ADD_WAIT cycle (one cycle after the read strobe).

## Structure
- Shared package:
  - state enum (LOAD, DRAIN, ADD_RD, ADD_WAIT, ADD_WR, DONE)
  - constants N_TERMS=8, ADDR_W=3, LEVELS=3, ADDS=7
- One sub-module, reduce_addr_gen: holds the level/pair counters and outputs a, b, last_pair and last_add, advancing on a step input from the FSM.

## Test plan
- Products 1..8 back-to-back → result_data=36 (0x24), result_valid exactly 23 cycles after the 8th accept; write strobes at addresses 0..7 in order.
- Eight products of 0xFF → result_data=0xF8 (modulo wrap); eight of 0x40 → 0x00.
- Monitor strobes and specifiers over a batch → read pairs exactly (0,1),(2,3),(4,5),(6,7),(0,2),(4,6),(0,4); each ADD_WR writes to a; update_adder_regs and update_file_reg never both high.
- Random prod_valid gaps plus result_ready held low 5 cycles → prod_ready=0 and result_data stable throughout DONE; prod_ready=1 the cycle after the handshake; a back-to-back second batch of 2×8 → 16.
- Assert reset in ADD_WAIT of add 3 → next cycle all strobes and result_valid are 0 and prod_ready=1 after deassert; a new batch of 1s → result 8.
- prod_valid held high during reduction with changing data → no extra writes, result unaffected.

Source files
------------

// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and sizing constants for the dot-product sequencer and its
// reduction address generator.
package dot_product_sequencer_pkg;

    localparam int unsigned N_TERMS = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned LEVELS  = 3;
    localparam int unsigned ADDS    = 7;

    typedef enum logic [2:0] {
        LOAD,
        DRAIN,
        ADD_RD,
        ADD_WAIT,
        ADD_WR,
        DONE
    } state_e;

    // First operand of pair k at a level: k * 2 * stride.
    function automatic logic [ADDR_W-1:0] pair_base(input logic [1:0] level,
                                                    input logic [1:0] pair);
        logic [ADDR_W-1:0] p;
        p = ADDR_W'(pair);
        return p << (level + 2'd1);
    endfunction

    function automatic logic [ADDR_W-1:0] level_stride(input logic [1:0] level);
        logic [ADDR_W-1:0] one;
        one = ADDR_W'(1);
        return one << level;
    endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Product stream, result stream and register-file control bundle of the
// dot-product sequencer.
interface dot_product_sequencer_if
    import dot_product_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);

    logic              prod_valid;
    logic [WIDTH-1:0]  prod_data;
    logic              prod_ready;
    logic [WIDTH-1:0]  sum_in;
    logic [WIDTH-1:0]  product_out;
    logic [ADDR_W-1:0] reg_specifier_one;
    logic [ADDR_W-1:0] reg_specifier_two;
    logic              update_adder_regs;
    logic              update_file_reg;
    logic              result_valid;
    logic [WIDTH-1:0]  result_data;
    logic              result_ready;
    logic              busy;

    modport master (
        input  prod_valid, prod_data, sum_in, result_ready,
        output prod_ready, product_out, reg_specifier_one, reg_specifier_two,
               update_adder_regs, update_file_reg, result_valid, result_data, busy
    );

    modport slave (
        output prod_valid, prod_data, sum_in, result_ready,
        input  prod_ready, product_out, reg_specifier_one, reg_specifier_two,
               update_adder_regs, update_file_reg, result_valid, result_data, busy
    );

endinterface

// File: rtl/dot_product_sequencer_reduce_addr_gen.sv
// Level/pair counters for the pairwise adder-tree reduction; presents the
// current read pair (a, b) and advances one pair per step.
module reduce_addr_gen
    import dot_product_sequencer_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] a_o,
    output logic [ADDR_W-1:0] b_o,
    output logic              last_pair_o,
    output logic              last_add_o
);

    logic [1:0] level_q, level_d;
    logic [1:0] pair_q, pair_d;
    logic [1:0] pair_max;

    always_comb begin
        case (level_q)
            2'd0:    pair_max = 2'd3;
            2'd1:    pair_max = 2'd1;
            default: pair_max = 2'd0;
        endcase
    end

    assign last_pair_o = (pair_q == pair_max);
    assign last_add_o  = last_pair_o && (level_q == 2'(LEVELS - 1));
    assign a_o         = pair_base(level_q, pair_q);
    assign b_o         = a_o + level_stride(level_q);

    always_comb begin
        level_d = level_q;
        pair_d  = pair_q;
        if (clear_i) begin
            level_d = '0;
            pair_d  = '0;
        end else if (step_i) begin
            if (last_pair_o) begin
                pair_d  = '0;
                level_d = last_add_o ? 2'd0 : level_q + 2'd1;
            end else begin
                pair_d  = pair_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= '0;
            pair_q  <= '0;
        end else begin
            level_q <= level_d;
            pair_q  <= pair_d;
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Loads eight products into the register file, then drives a three-level
// pairwise reduction through it and presents the final sum.
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)(
    input  logic                   clk,
    input  logic                   reset,
    dot_product_sequencer_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              last_q, last_d;

    logic              prod_ready_q, prod_ready_d;
    logic [WIDTH-1:0]  product_out_q, product_out_d;
    logic [ADDR_W-1:0] spec_one_q, spec_one_d;
    logic [ADDR_W-1:0] spec_two_q, spec_two_d;
    logic              upd_add_q, upd_add_d;
    logic              upd_file_q, upd_file_d;
    logic              result_valid_q, result_valid_d;
    logic [WIDTH-1:0]  result_data_q, result_data_d;
    logic              busy_q, busy_d;

    logic              step, clear;
    logic [ADDR_W-1:0] pair_a, pair_b;
    logic              last_pair, last_add;

    reduce_addr_gen u_addr_gen (
        .clk_i       (clk),
        .rst_i       (reset),
        .clear_i     (clear),
        .step_i      (step),
        .a_o         (pair_a),
        .b_o         (pair_b),
        .last_pair_o (last_pair),
        .last_add_o  (last_add)
    );

    // Outputs are registered from the next state, so each state's strobes
    // appear in the cycle the FSM occupies that state. The generator steps on
    // the edge that issues a read; spec_one_q keeps 'a' for the write-back.
    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        sum_d         = sum_q;
        last_d        = last_q;
        product_out_d = product_out_q;
        spec_one_d    = spec_one_q;
        spec_two_d    = spec_two_q;
        result_data_d = result_data_q;
        upd_add_d     = 1'b0;
        upd_file_d    = 1'b0;
        step          = 1'b0;
        clear         = 1'b0;

        case (state_q)
            LOAD: begin
                if (prod_ready_q && bus.prod_valid) begin
                    upd_file_d    = 1'b1;
                    spec_one_d    = load_cnt_q;
                    product_out_d = bus.prod_data;
                    load_cnt_d    = load_cnt_q + 1'b1;
                    if (load_cnt_q == ADDR_W'(N_TERMS - 1)) state_d = DRAIN;
                end
            end
            DRAIN, ADD_WR: begin
                if (state_q == ADD_WR && last_q) begin
                    state_d       = DONE;
                    result_data_d = sum_q;
                end else begin
                    state_d    = ADD_RD;
                    upd_add_d  = 1'b1;
                    spec_one_d = pair_a;
                    spec_two_d = pair_b;
                    step       = 1'b1;
                    last_d     = last_pair && last_add;
                end
            end
            ADD_RD: state_d = ADD_WAIT;
            ADD_WAIT: begin
                state_d       = ADD_WR;
                sum_d         = bus.sum_in;
                upd_file_d    = 1'b1;
                product_out_d = bus.sum_in;
            end
            DONE: begin
                if (result_valid_q && bus.result_ready) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                    last_d     = 1'b0;
                    clear      = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase

        result_valid_d = (state_d == DONE);
        prod_ready_d   = (state_d == LOAD);
        busy_d         = (state_d != LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= LOAD;
            load_cnt_q     <= '0;
            sum_q          <= '0;
            last_q         <= 1'b0;
            prod_ready_q   <= 1'b1;
            product_out_q  <= '0;
            spec_one_q     <= '0;
            spec_two_q     <= '0;
            upd_add_q      <= 1'b0;
            upd_file_q     <= 1'b0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            sum_q          <= sum_d;
            last_q         <= last_d;
            prod_ready_q   <= prod_ready_d;
            product_out_q  <= product_out_d;
            spec_one_q     <= spec_one_d;
            spec_two_q     <= spec_two_d;
            upd_add_q      <= upd_add_d;
            upd_file_q     <= upd_file_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.prod_ready        = prod_ready_q;
    assign bus.product_out       = product_out_q;
    assign bus.reg_specifier_one = spec_one_q;
    assign bus.reg_specifier_two = spec_two_q;
    assign bus.update_adder_regs = upd_add_q;
    assign bus.update_file_reg   = upd_file_q;
    assign bus.result_valid      = result_valid_q;
    assign bus.result_data       = result_data_q;
    assign bus.busy              = busy_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a behavioural register file
// and external adder; expected sums and address orders are hand-computed.
module tb_dot_product_sequencer;
    import dot_product_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dot_product_sequencer_if #(.WIDTH(8)) bus();

    dot_product_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file: read strobe has priority over the write strobe.
    logic [7:0] rf [8];
    logic [7:0] t1 = '0;
    logic [7:0] t2 = '0;
    always @(posedge clk) begin
        if (bus.update_adder_regs) begin
            t1 <= rf[bus.reg_specifier_one];
            t2 <= rf[bus.reg_specifier_two];
        end else if (bus.update_file_reg) begin
            rf[bus.reg_specifier_one] <= bus.product_out;
        end
    end
    assign bus.sum_in = t1 + t2;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int wr_addr[$];
    int wr_data[$];
    int rd_a[$];
    int rd_b[$];
    int overlap = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.update_adder_regs && bus.update_file_reg) overlap++;
            if (bus.update_file_reg) begin
                wr_addr.push_back(int'(bus.reg_specifier_one));
                wr_data.push_back(int'(bus.product_out));
            end
            if (bus.update_adder_regs) begin
                rd_a.push_back(int'(bus.reg_specifier_one));
                rd_b.push_back(int'(bus.reg_specifier_two));
            end
        end
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        rd_a.delete();
        rd_b.delete();
    endtask

    // Called at a negedge; returns at the negedge of the DRAIN cycle.
    task automatic load_batch(input logic [7:0] v [8], input logic [7:0] gaps,
                              output int unsigned c_acc);
        int unsigned w;
        c_acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (gaps[i]) begin
                bus.prod_valid = 1'b0;
                @(negedge clk);
            end
            w = 0;
            while (!bus.prod_ready && w < 50) begin
                bus.prod_valid = 1'b0;
                @(negedge clk);
                w++;
            end
            if (!bus.prod_ready) begin
                check("load_ready_timeout", 32'd0, 32'd1);
                return;
            end
            bus.prod_valid = 1'b1;
            bus.prod_data  = v[i];
            c_acc = cyc;
            @(negedge clk);
        end
        bus.prod_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int unsigned c_acc, input int hold,
                               input logic [7:0] exp, input bit noisy);
        int unsigned w;
        w = 0;
        while (!bus.result_valid && w < 200) begin
            if (noisy) begin
                bus.prod_valid = 1'b1;
                bus.prod_data  = 8'(w * 37 + 5);
            end
            @(negedge clk);
            w++;
        end
        bus.prod_valid = 1'b0;
        if (!bus.result_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_latency"}, cyc - c_acc, 32'd23);
        check({tag, "_data"}, 32'(bus.result_data), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_ready"}, 32'(bus.prod_ready), 32'd0);
            check({tag, "_hold_valid"}, 32'(bus.result_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(bus.result_data), 32'(exp));
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(bus.prod_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(bus.result_valid), 32'd0);
    endtask

    task automatic check_order(input string tag, input logic [7:0] v [8]);
        int ea [7] = '{0, 2, 4, 6, 0, 4, 0};
        int eb [7] = '{1, 3, 5, 7, 2, 6, 4};
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd15);
        check({tag, "_nreads"}, 32'(rd_a.size()), 32'd7);
        if (wr_addr.size() == 15) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("%s_ld_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
                check($sformatf("%s_ld_data%0d", tag, i), 32'(wr_data[i]), 32'(v[i]));
            end
            for (int i = 0; i < 7; i++)
                check($sformatf("%s_wb_addr%0d", tag, i), 32'(wr_addr[8 + i]), 32'(ea[i]));
        end
        if (rd_a.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                check($sformatf("%s_rd_a%0d", tag, i), 32'(rd_a[i]), 32'(ea[i]));
                check($sformatf("%s_rd_b%0d", tag, i), 32'(rd_b[i]), 32'(eb[i]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v [8];
        int unsigned c;
        int unsigned w;
        int esum [7] = '{3, 7, 11, 15, 10, 26, 36};

        bus.prod_valid   = 1'b0;
        bus.prod_data    = '0;
        bus.result_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_upd_add", 32'(bus.update_adder_regs), 32'd0);
        check("rst_upd_file", 32'(bus.update_file_reg), 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result_data", 32'(bus.result_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_prod_ready", 32'(bus.prod_ready), 32'd1);

        // Products 1..8 back to back: sum 36.
        clear_mon();
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
        load_batch(v, 8'h00, c);
        check("b1_busy_drain", 32'(bus.busy), 32'd1);
        check("b1_ready_drain", 32'(bus.prod_ready), 32'd0);
        wait_result("b1", c, 0, 8'h24, 1'b0);
        check_order("b1", v);
        if (wr_data.size() == 15)
            for (int i = 0; i < 7; i++)
                check($sformatf("b1_wb_data%0d", i), 32'(wr_data[8 + i]), 32'(esum[i]));

        // Modulo wrap cases.
        for (int i = 0; i < 8; i++) v[i] = 8'hFF;
        load_batch(v, 8'b0010_0100, c);
        wait_result("ff", c, 0, 8'hF8, 1'b0);
        for (int i = 0; i < 8; i++) v[i] = 8'h40;
        load_batch(v, 8'h00, c);
        wait_result("x40", c, 0, 8'h00, 1'b0);

        // Gapped load, consumer stalls 5 cycles, then an immediate second batch.
        v = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
        load_batch(v, 8'b1010_0110, c);
        wait_result("gap", c, 5, 8'h1F, 1'b0);
        for (int i = 0; i < 8; i++) v[i] = 8'd2;
        load_batch(v, 8'h00, c);
        wait_result("b2b", c, 0, 8'd16, 1'b0);

        // prod_valid held high with changing data during the reduction.
        clear_mon();
        for (int i = 0; i < 8; i++) v[i] = 8'(10 * (i + 1));
        load_batch(v, 8'h00, c);
        wait_result("noise", c, 0, 8'h68, 1'b1);
        check_order("noise", v);

        // Reset during ADD_WAIT of add 3.
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
        load_batch(v, 8'h00, c);
        w = 0;
        while (cyc != c + 12 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("mid_reach_wait", cyc - c, 32'd12);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_upd_add", 32'(bus.update_adder_regs), 32'd0);
        check("mid_upd_file", 32'(bus.update_file_reg), 32'd0);
        check("mid_result_valid", 32'(bus.result_valid), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_prod_ready", 32'(bus.prod_ready), 32'd1);
        clear_mon();
        for (int i = 0; i < 8; i++) v[i] = 8'd1;
        load_batch(v, 8'h00, c);
        wait_result("after_rst", c, 0, 8'd8, 1'b0);
        check_order("after_rst", v);

        check("strobe_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
